// File: rtl/lavadora_panel.sv
// lavadora_panel: washer front-panel input stage. It debounces the buttons, selects the mode, validates the start, and holds the lockout.
// Optional key-click output enabled by defining PANEL_CLICK_EN.
module lavadora_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_LOAD        = 4,
    parameter int LOCKOUT_CYCLES  = 15
`ifdef PANEL_CLICK_EN
    , parameter int CLICK_CYCLES  = 2
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       door_closed,
    input  logic [3:0] load_raw,
    output logic       start,
    output logic [1:0] mode,
    output logic [3:0] load,
    output logic       door_lock,
    output logic       overload,
    output logic       fault
`ifdef PANEL_CLICK_EN
    , output logic     click
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, LOCKOUT} state_t;

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] LK_LAST = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0] MAX_L   = 4'(MAX_LOAD);

    state_t     state, state_n;
    logic [1:0] raw, lvl, lvl_d, press;
    logic [3:0] db_cnt [2];
    logic [7:0] lk_cnt;
    logic       door_d, start_press, mode_adv, bad_load, accept;

    assign raw         = {btn_mode, btn_start};
    assign press       = lvl & ~lvl_d;
    assign start_press = press[0];
    assign mode_adv    = press[1] && state == IDLE;
    assign bad_load    = load_raw > MAX_L;

    // Per-button debounce: a level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl       <= '0;
            lvl_d     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            lvl_d <= lvl;
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    lvl[i]    <= ~lvl[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 4'd1;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // Next state and Moore outputs; a start press is accepted only with a closed door and legal load
    always_comb begin
        state_n   = state;
        start     = 1'b0;
        door_lock = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start_press && !bad_load && door_closed) begin
                    accept  = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                start     = 1'b1;
                door_lock = 1'b1;
                state_n   = LOCKOUT;
            end
            LOCKOUT: begin
                door_lock = 1'b1;
                if (lk_cnt == LK_LAST) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Mode, load capture, sticky flags and lockout timer
    always_ff @(posedge clk) begin
        if (rst) begin
            mode     <= '0;
            load     <= '0;
            overload <= 1'b0;
            fault    <= 1'b0;
            lk_cnt   <= '0;
            door_d   <= 1'b0;
        end else begin
            door_d <= door_closed;
            lk_cnt <= (state == LOCKOUT) ? lk_cnt + 8'd1 : 8'd0;
            if (state == IDLE) load <= load_raw;
            if (mode_adv) mode <= (mode == 2'd2) ? 2'd0 : mode + 2'd1;
            if (accept) begin
                overload <= 1'b0;
                fault    <= 1'b0;
            end else if (state == IDLE && start_press) begin
                if (bad_load) overload <= 1'b1;
                if (!door_closed) fault <= 1'b1;
            end
            if (state == LOCKOUT && door_d && !door_closed) fault <= 1'b1;
        end
    end

`ifdef PANEL_CLICK_EN
    logic [7:0] click_cnt;

    assign click = click_cnt != 8'd0;

    // Click width counter; any state- or mode-changing event restarts it
    always_ff @(posedge clk) begin
        if (rst) click_cnt <= '0;
        else if (accept || mode_adv) click_cnt <= 8'(CLICK_CYCLES);
        else if (click_cnt != 8'd0) click_cnt <= click_cnt - 8'd1;
    end
`endif

endmodule

// File: tb/tb_lavadora_panel.sv
// tb_lavadora_panel: directed table-driven bench for lavadora_panel with hand-written timing sequences.
module tb_lavadora_panel;

    logic       clk = 1'b0;
    logic       rst, btn_start, btn_mode, door_closed;
    logic [3:0] load_raw;
    logic       start, door_lock, overload, fault;
    logic [1:0] mode;
    logic [3:0] load;
`ifdef PANEL_CLICK_EN
    logic       click;
`endif

    lavadora_panel dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_mode(btn_mode),
        .door_closed(door_closed), .load_raw(load_raw), .start(start), .mode(mode),
        .load(load), .door_lock(door_lock), .overload(overload), .fault(fault)
`ifdef PANEL_CLICK_EN
        , .click(click)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {int bs, bm, dc, lr, n, starts, m, ld, lk, ov, f;} seg_t;
    seg_t tbl[23];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    initial begin
        int cnt;
        //          bs bm dc lr  n  st m  ld lk ov f
        tbl[0]  = '{0, 0, 1, 3, 10, 0, 0, 3, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 3, 25, 1, 0, 3, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 3, 10, 0, 0, 3, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 3,  6, 0, 1, 3, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 3,  6, 0, 1, 3, 0, 0, 0};
        tbl[5]  = '{0, 1, 1, 3,  6, 0, 2, 3, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 3,  6, 0, 2, 3, 0, 0, 0};
        tbl[7]  = '{0, 1, 1, 3,  6, 0, 0, 3, 0, 0, 0};
        tbl[8]  = '{0, 0, 1, 3,  6, 0, 0, 3, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 3,  6, 0, 1, 3, 0, 0, 0};
        tbl[10] = '{0, 0, 1, 3,  6, 0, 1, 3, 0, 0, 0};
        tbl[11] = '{1, 0, 1, 5,  8, 0, 1, 5, 0, 1, 0};
        tbl[12] = '{0, 0, 1, 5,  8, 0, 1, 5, 0, 1, 0};
        tbl[13] = '{1, 0, 1, 4, 25, 1, 1, 4, 0, 0, 0};
        tbl[14] = '{0, 0, 1, 4,  8, 0, 1, 4, 0, 0, 0};
        tbl[15] = '{1, 0, 0, 4,  8, 0, 1, 4, 0, 0, 1};
        tbl[16] = '{0, 0, 0, 4,  8, 0, 1, 4, 0, 0, 1};
        tbl[17] = '{1, 0, 0, 9,  8, 0, 1, 9, 0, 1, 1};
        tbl[18] = '{0, 0, 1, 2,  8, 0, 1, 2, 0, 1, 1};
        tbl[19] = '{1, 0, 1, 2, 25, 1, 1, 2, 0, 0, 0};
        tbl[20] = '{0, 0, 1, 2,  8, 0, 1, 2, 0, 0, 0};
        tbl[21] = '{1, 0, 1, 2,  3, 0, 1, 2, 0, 0, 0};
        tbl[22] = '{0, 0, 1, 2, 10, 0, 1, 2, 0, 0, 0};

        rst = 1'b1; btn_start = 1'b0; btn_mode = 1'b0; door_closed = 1'b1; load_raw = 4'd3;
        idle(2);
        chk("rst start", 8'(start), 8'd0);
        chk("rst mode", 8'(mode), 8'd0);
        chk("rst load", 8'(load), 8'd0);
        chk("rst door_lock", 8'(door_lock), 8'd0);
        chk("rst overload", 8'(overload), 8'd0);
        chk("rst fault", 8'(fault), 8'd0);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            btn_start   = 1'(tbl[i].bs);
            btn_mode    = 1'(tbl[i].bm);
            door_closed = 1'(tbl[i].dc);
            load_raw    = 4'(tbl[i].lr);
            cnt = 0;
            for (int c = 0; c < tbl[i].n; c++) begin
                tick();
                if (start) cnt++;
            end
            chk($sformatf("seg%0d starts", i), 8'(cnt), 8'(tbl[i].starts));
            chk($sformatf("seg%0d mode", i), 8'(mode), 8'(tbl[i].m));
            chk($sformatf("seg%0d load", i), 8'(load), 8'(tbl[i].ld));
            chk($sformatf("seg%0d door_lock", i), 8'(door_lock), 8'(tbl[i].lk));
            chk($sformatf("seg%0d overload", i), 8'(overload), 8'(tbl[i].ov));
            chk($sformatf("seg%0d fault", i), 8'(fault), 8'(tbl[i].f));
        end

        // start latency, lock width, load freeze, mode press ignored in LOCKOUT
        door_closed = 1'b1;
        for (int i = 0; i < 30; i++) begin
            btn_start = 1'b1;
            load_raw  = (i >= 5) ? 4'd7 : 4'd3;
            btn_mode  = (i >= 6 && i < 14);
            tick();
            chk($sformatf("A%0d start", i), 8'(start), 8'(i == 4));
            chk($sformatf("A%0d door_lock", i), 8'(door_lock), 8'(i >= 4 && i <= 19));
            chk($sformatf("A%0d load", i), 8'(load), (i >= 21) ? 8'd7 : 8'd3);
            chk($sformatf("A%0d mode", i), 8'(mode), 8'd1);
        end
        btn_start = 1'b0; btn_mode = 1'b0; load_raw = 4'd3;
        idle(10);

        // door opened during LOCKOUT: fault sets, lockout runs to completion
        for (int i = 0; i < 25; i++) begin
            btn_start   = 1'b1;
            door_closed = !(i >= 8 && i < 12);
            tick();
            chk($sformatf("B%0d start", i), 8'(start), 8'(i == 4));
            chk($sformatf("B%0d door_lock", i), 8'(door_lock), 8'(i >= 4 && i <= 19));
            chk($sformatf("B%0d fault", i), 8'(fault), 8'(i >= 8));
        end
        btn_start = 1'b0;
        idle(10);

        // bouncing start 1,0,1,0 then stable: one pulse after the stable run
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            btn_start = (i == 1 || i == 3) ? 1'b0 : 1'b1;
            tick();
            if (start) cnt++;
            chk($sformatf("C%0d start", i), 8'(start), 8'(i == 8));
        end
        chk("C pulses", 8'(cnt), 8'd1);
        chk("C fault cleared", 8'(fault), 8'd0);
        btn_start = 1'b0;
        idle(10);

        // simultaneous start and mode press: ISSUE shows the advanced mode
        for (int i = 0; i < 8; i++) begin
            btn_start = 1'b1;
            btn_mode  = 1'b1;
            tick();
            if (i == 3) chk("E mode before", 8'(mode), 8'd1);
            if (i == 4) begin
                chk("E start", 8'(start), 8'd1);
                chk("E mode", 8'(mode), 8'd2);
            end
        end
        btn_start = 1'b0; btn_mode = 1'b0;
        idle(25);

        // reset in the middle of LOCKOUT
        btn_start = 1'b1;
        idle(10);
        chk("D lock before rst", 8'(door_lock), 8'd1);
        rst = 1'b1;
        tick();
        chk("D door_lock", 8'(door_lock), 8'd0);
        chk("D start", 8'(start), 8'd0);
        chk("D mode", 8'(mode), 8'd0);
        chk("D load", 8'(load), 8'd0);
        rst = 1'b0; btn_start = 1'b0;
        idle(5);
        chk("D idle door_lock", 8'(door_lock), 8'd0);
        chk("D idle load", 8'(load), 8'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lavadora_panel.md
Name: lavadora_panel

Overview:
- Front-panel input stage directly upstream of the washer cycle controller; produces its start, mode and load inputs.
- Debounces the raw start and mode push-buttons and cycles the wash mode.
- Validates load and door state before issuing a single-cycle start pulse.
- Holds a door-lock/lockout window after each start so the controller is not restarted mid-cycle.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable samples required before a debounced button level changes (1-15).
- MAX_LOAD, 4, largest accepted load value; a larger load_raw rejects the start.
- LOCKOUT_CYCLES, 15, cycles spent in LOCKOUT after a start is issued (1-255).
- CLICK_CYCLES, 2, width in cycles of the key-click pulse (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- btn_start  in  1  raw start button, active-high, may bounce.
- btn_mode  in  1  raw mode button, active-high, may bounce.
- door_closed  in  1  door switch, 1 = closed.
- load_raw  in  4  load sensor value, 0-15 lb.
- start  out  1  one-cycle start pulse to the cycle controller.
- mode  out  2  selected mode (0 = wash, 1 = rinse, 2 = spin); never 3.
- load  out  4  load value presented to the controller.
- door_lock  out  1  door latch solenoid, 1 = locked.
- overload  out  1  sticky: last start rejected because load_raw > MAX_LOAD.
- fault  out  1  sticky: door open at a start press, or opened during LOCKOUT.
- click  out  1  key-click pulse; present only when PANEL_CLICK_EN is defined.

Behaviour:
- Reset:
  - All outputs 0, state IDLE.
  - Debounce counters 0, debounced levels 0, lockout counter 0.
  - Reset in any state returns to IDLE on the next edge, so door_lock is 0 the cycle after rst is sampled.
- Debounce, per button, all registers on clk:
  - While raw != debounced level, the counter increments; on reaching DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - raw == debounced level clears the counter.
  - A press event is a debounced 0->1 transition, one cycle wide.
  - A clean raw rise sampled at edge k makes the press event true during the cycle after edge k+DEBOUNCE_CYCLES-1.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- mode:
  - A mode press in IDLE advances mode 0->1->2->0 (wrap at 2).
  - Mode presses in ISSUE or LOCKOUT are ignored; mode is held.
- load:
  - load <= load_raw every cycle in IDLE.
  - Frozen in ISSUE and LOCKOUT.
- FSM states: IDLE, ISSUE, LOCKOUT.
  - IDLE, on a start press:
    - load_raw > MAX_LOAD sets overload=1.
    - door_closed=0 sets fault=1; both flags may set in the same cycle.
    - Either condition keeps the state in IDLE.
    - Otherwise clear overload and fault, and go to ISSUE.
    - Boundary: load_raw == MAX_LOAD is accepted.
  - ISSUE (exactly 1 cycle): start=1, door_lock=1; go to LOCKOUT with the counter cleared.
  - LOCKOUT:
    - door_lock=1, start=0; the counter increments each cycle.
    - When the counter reaches LOCKOUT_CYCLES-1, go to IDLE; door_lock=0 from the first IDLE cycle.
    - Start presses are ignored.
    - door_closed falling sets fault=1; the lockout still runs to completion.
- Simultaneous start and mode presses in IDLE: the mode advances and the start is evaluated in the same cycle; ISSUE presents the new mode.
- start is high for exactly one cycle per accepted press, DEBOUNCE_CYCLES+1 edges after the raw rise is first sampled.
- Holding btn_start high does not retrigger; a new press requires a debounced release first.
- Flags stay set until the next accepted start or rst.

Optional Feature:
- Macro: PANEL_CLICK_EN.
- When defined:
  - The click port exists.
  - Every press event that changes state or mode (accepted start, mode advance in IDLE) drives click=1 for CLICK_CYCLES cycles.
  - A new event during a click restarts the width count.
  - Rejected starts and ignored presses produce no click.
- When undefined: the click port and its counter are absent; all other behaviour is identical.

Test Plan:
- rst 2 cycles, then idle 10 cycles -> all outputs 0, mode=0, load follows load_raw.
- door_closed=1, load_raw=3, btn_start clean rise held 20 cycles -> start high exactly 1 cycle, 5 edges after the rise; door_lock high 16 cycles (ISSUE + 15); load=3 held throughout.
- btn_start bounces 1,0,1,0 at 1-cycle spacing, then stable high -> single start pulse; 3-cycle glitch alone -> no pulse.
- btn_mode pressed 4 times with releases in IDLE -> mode 1,2,0,1; mode press during LOCKOUT -> mode unchanged.
- load_raw=5 with start press -> start never asserted, overload=1, state IDLE. Then load_raw=4 with a new press -> start pulse, overload=0.
- door_closed=0 with start press -> fault=1, no start. During LOCKOUT: door opens -> fault=1, door_lock stays high to the end; rst mid-LOCKOUT -> door_lock=0 next cycle.
